// File: rtl/ftoi_pkg.sv
// ftoi_pkg: shared float field bounds, constants and handshake state encoding
package ftoi_pkg;
  localparam int FP_BIAS = 127;
  localparam int EXP_HI = 30;
  localparam int EXP_LO = 23;
  localparam int MAN_HI = 22;
  localparam int MAN_LO = 0;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  typedef enum logic [3:0] {
    GET_A         = 4'd0,
    UNPACK        = 4'd1,
    SPECIAL_CASES = 4'd2,
    CONVERT       = 4'd3,
    PACK          = 4'd4,
    PUT_Z         = 4'd5
  } state_t;
endpackage

// File: rtl/ftoi.sv
// ftoi: iterative float-to-int32 converter, truncating toward zero
//   clk, rst (async active-low)
//   input_a/input_a_stb/input_a_ack    : float operand handshake
//   output_z/output_z_stb/output_z_ack : int32 result handshake
module ftoi
  import ftoi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);
  state_t      state;
  logic [31:0] a, a_m, z;
  logic [9:0]  a_e;
  logic        a_s;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= GET_A;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
      a            <= '0;
      a_m          <= '0;
      a_e          <= '0;
      a_s          <= 1'b0;
      z            <= '0;
    end else
      case (state)
        GET_A: begin
          input_a_ack <= 1'b1;
          if (input_a_ack && input_a_stb) begin
            a           <= input_a;
            input_a_ack <= 1'b0;
            state       <= UNPACK;
          end
        end
        UNPACK: begin
          a_m   <= {1'b1, a[MAN_HI:MAN_LO], 8'b0};
          a_e   <= {2'b0, a[EXP_HI:EXP_LO]} - 10'(FP_BIAS);
          a_s   <= a[31];
          state <= SPECIAL_CASES;
        end
        SPECIAL_CASES:
          if ($signed(a_e) < 10'sd0) begin
            z     <= '0;
            state <= PUT_Z;
          end else if ($signed(a_e) > 10'sd30) begin
            z     <= INT_MIN;
            state <= PUT_Z;
          end else
            state <= CONVERT;
        // shift the integer part down until the binary point sits below bit 0
        CONVERT:
          if (a_e != 10'd31) begin
            a_m <= a_m >> 1;
            a_e <= a_e + 10'd1;
          end else
            state <= PACK;
        PACK: begin
          z     <= a_s ? -a_m : a_m;
          state <= PUT_Z;
        end
        PUT_Z: begin
          output_z_stb <= 1'b1;
          output_z     <= z;
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            state        <= GET_A;
          end
        end
        default: state <= GET_A;
      endcase
endmodule

// File: tb/tb_ftoi.sv
// tb_ftoi: self-checking bench for ftoi
module tb_ftoi;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] input_a = '0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  ftoi dut (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] model(input logic [31:0] f);
    int e;
    logic [63:0] mag;
    e = int'(f[30:23]) - 127;
    if (e < 0) return 32'h0;
    if (e > 30) return 32'h8000_0000;
    mag = {40'b0, 1'b1, f[22:0]};
    mag = (e >= 23) ? mag << (e - 23) : mag >> (23 - e);
    return f[31] ? -mag[31:0] : mag[31:0];
  endfunction
  function automatic int lat_of(input logic [31:0] f);
    int e;
    e = int'(f[30:23]) - 127;
    return (e < 0 || e > 30) ? 3 : 36 - e;
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout %s", name);
  endtask
  logic        pending = 1'b0;
  logic        seen = 1'b0;
  logic [31:0] exp_z = '0;
  int          exp_lat = 0;
  int          cap = 0;
  always @(negedge clk) begin
    if (!rst) begin
      pending = 1'b0;
      seen = 1'b0;
    end else begin
      if (output_z_stb) begin
        if (!seen) begin
          check("stb_pending", 32'(pending), 32'd1);
          check("latency", 32'(cyc - cap), 32'(exp_lat));
        end
        check("model_z", output_z, exp_z);
        check("ack_in_put", 32'(input_a_ack), 32'd0);
        seen = 1'b1;
      end
      if (pending && !output_z_stb && input_a_ack)
        check("ack_busy", 32'(input_a_ack), 32'd0);
      if (output_z_stb && output_z_ack) begin
        seen = 1'b0;
        pending = 1'b0;
      end
      if (input_a_stb && input_a_ack) begin
        pending = 1'b1;
        exp_z = model(input_a);
        exp_lat = lat_of(input_a);
        cap = cyc + 1;
      end
    end
  end
  task automatic run_op(input logic [31:0] f, input logic [31:0] lit, input int lat,
                        input int hold, output int wait_n);
    int n;
    check($sformatf("lit_z_%h", f), model(f), lit);
    check($sformatf("lit_lat_%h", f), 32'(lat_of(f)), 32'(lat));
    input_a = f;
    input_a_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < 50) begin @(posedge clk); #1; n++; end
    wait_n = n;
    if (!input_a_ack) timeout("accept");
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    n = 0;
    while (!output_z_stb && n < 60) begin @(posedge clk); #1; n++; end
    if (!output_z_stb) timeout("result");
    check($sformatf("z_%h", f), output_z, lit);
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_stb", 32'(output_z_stb), 32'd1);
      check("hold_z", output_z, lit);
      check("hold_ack", 32'(input_a_ack), 32'd0);
    end
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
    check("stb_drop", 32'(output_z_stb), 32'd0);
    check("ack_reentry", 32'(input_a_ack), 32'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(input_a_ack), 32'd0);
    check("rst_stb", 32'(output_z_stb), 32'd0);
    check("rst_z", output_z, 32'd0);
    rst = 1'b1;
    run_op(32'h3F80_0000, 32'h0000_0001, 36, 0, n);
    run_op(32'hC020_0000, 32'hFFFF_FFFE, 35, 0, n);
    run_op(32'h4EFF_FFFF, 32'h7FFF_FF80, 6, 0, n);
    run_op(32'h4F00_0000, 32'h8000_0000, 3, 0, n);
    run_op(32'h7FC0_0000, 32'h8000_0000, 3, 0, n);
    run_op(32'hFF80_0000, 32'h8000_0000, 3, 0, n);
    run_op(32'h3F7F_FFFF, 32'h0000_0000, 3, 0, n);
    run_op(32'h8000_0001, 32'h0000_0000, 3, 0, n);
    run_op(32'hCF00_0000, 32'h8000_0000, 3, 0, n);
    run_op(32'h42F6_E979, 32'h0000_007B, 30, 0, n);
    run_op(32'h4B00_0001, 32'h0080_0001, 13, 0, n);
    run_op(32'h4120_0000, 32'h0000_000A, 33, 10, n);
    run_op(32'hC2F6_E979, 32'hFFFF_FF85, 30, 0, n);
    check("accept_gap", 32'(n), 32'd1);
    input_a = 32'h3F80_0000;
    input_a_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < 50) begin @(posedge clk); #1; n++; end
    if (!input_a_ack) timeout("accept_rst");
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_ack", 32'(input_a_ack), 32'd0);
    check("mid_rst_stb", 32'(output_z_stb), 32'd0);
    check("mid_rst_z", output_z, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    run_op(32'h4040_0000, 32'h0000_0003, 35, 0, n);
    input_a = 32'h4F00_0000;
    input_a_stb = 1'b1;
    n = 0;
    while (!input_a_ack && n < 50) begin @(posedge clk); #1; n++; end
    if (!input_a_ack) timeout("accept_async");
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    n = 0;
    while (!output_z_stb && n < 60) begin @(posedge clk); #1; n++; end
    if (!output_z_stb) timeout("result_async");
    #1;
    rst = 1'b0;
    #1;
    check("async_stb", 32'(output_z_stb), 32'd0);
    check("async_z", output_z, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run_op(32'hC040_0000, 32'hFFFF_FFFD, 35, 0, n);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
